// File: rtl/matrix_result_streamer_pkg.sv
// Shared definitions for the matrix result streamer: element width and FSM state type.
package matrix_result_streamer_pkg;

  localparam int unsigned ELEM_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/matrix_result_streamer.sv
// Captures an NxN result matrix in one cycle and streams it row-major over a valid/ready port.
module matrix_result_streamer
  import matrix_result_streamer_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic                           i_clk,
  input  logic                           i_arst_n,
  input  logic [N-1:0][N-1:0][ELEM_W-1:0] i_c,
  input  logic                           i_validResult,
  output logic [ELEM_W-1:0]              o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [IDX_W-1:0]               o_row,
  output logic [IDX_W-1:0]               o_col,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_overrun
);

  if ((N < 3) || (N > 255)) begin : g_n_range
    $error("matrix_result_streamer: N must be within 3..255");
  end

  state_e                           state_q, state_d;
  logic [N-1:0][N-1:0][ELEM_W-1:0]  mat_q;
  logic [IDX_W-1:0]                 row_d, col_d, step_row, step_col;
  logic [ELEM_W-1:0]                data_d;
  logic                             last_d, overrun_d, capture, xfer;

  // Next-state and next-output decode; a capture overrides any other update.
  always_comb begin
    state_d   = state_q;
    row_d     = o_row;
    col_d     = o_col;
    data_d    = o_data;
    last_d    = o_last;
    overrun_d = 1'b0;
    capture   = 1'b0;
    xfer      = (state_q == ST_STREAM) && i_ready;
    step_row  = o_row;
    step_col  = o_col + IDX_W'(1);
    if (o_col == IDX_W'(N - 1)) begin
      step_col = '0;
      step_row = o_row + IDX_W'(1);
    end

    case (state_q)
      ST_IDLE: capture = i_validResult;
      ST_STREAM: begin
        if (xfer && o_last) begin
          capture = i_validResult;
          if (!i_validResult) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end else begin
          // A new result while the previous matrix is still draining is dropped.
          overrun_d = i_validResult;
          if (xfer) begin
            row_d  = step_row;
            col_d  = step_col;
            data_d = mat_q[step_row][step_col];
            last_d = (step_row == IDX_W'(N - 1)) && (step_col == IDX_W'(N - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      state_d = ST_STREAM;
      row_d   = '0;
      col_d   = '0;
      data_d  = i_c[0][0];
      last_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_IDLE;
      o_row     <= '0;
      o_col     <= '0;
      o_data    <= '0;
      o_last    <= 1'b0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_row     <= row_d;
      o_col     <= col_d;
      o_data    <= data_d;
      o_last    <= last_d;
      o_valid   <= (state_d == ST_STREAM);
      o_busy    <= (state_d == ST_STREAM);
      o_overrun <= overrun_d;
    end
  end

  // Matrix buffer is data-only and needs no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mat_q <= i_c;
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench: N=3 vector table plus N=4 directed and random traffic against a queue model.
module tb_matrix_result_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=4 instance
  logic [3:0][3:0][31:0] c4;
  logic                  vr4, rdy4;
  logic [31:0]           data4;
  logic [1:0]            row4, col4;
  logic                  valid4, last4, busy4, ovr4;

  matrix_result_streamer #(.N(4)) u_dut4 (
    .i_clk(clk), .i_arst_n(rst_n), .i_c(c4), .i_validResult(vr4),
    .o_data(data4), .o_valid(valid4), .i_ready(rdy4),
    .o_row(row4), .o_col(col4), .o_last(last4), .o_busy(busy4), .o_overrun(ovr4)
  );

  // N=3 instance
  logic [2:0][2:0][31:0] c3;
  logic                  vr3, rdy3;
  logic [31:0]           data3;
  logic [1:0]            row3, col3;
  logic                  valid3, last3, busy3, ovr3;

  matrix_result_streamer #(.N(3)) u_dut3 (
    .i_clk(clk), .i_arst_n(rst_n), .i_c(c3), .i_validResult(vr3),
    .o_data(data3), .o_valid(valid3), .i_ready(rdy3),
    .o_row(row3), .o_col(col3), .o_last(last3), .o_busy(busy3), .o_overrun(ovr3)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } elem_t;

  typedef struct {
    logic        vr;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  er;
    logic [1:0]  ec;
    logic        el;
  } vec_t;

  elem_t q[$];
  logic  exp_ovr;
  int    n_cmp, n_bad, xfer_cnt, ovr_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream for a matrix accepted at this edge: every element, row-major.
  task automatic push_matrix();
    elem_t e;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        e.data = c4[r][c];
        e.row  = 2'(r);
        e.col  = 2'(c);
        e.last = (r == 3) && (c == 3);
        q.push_back(e);
      end
    end
  endtask

  // Compare N=4 outputs with the model, then advance the model by the coming edge.
  task automatic check_and_step();
    if (!rst_n) begin
      chk("rst_valid", 32'(valid4), 32'd0);
      chk("rst_data", data4, 32'd0);
      chk("rst_rowcol", {28'd0, row4, col4}, 32'd0);
      chk("rst_flags", {29'd0, last4, busy4, ovr4}, 32'd0);
      q.delete();
      exp_ovr = 1'b0;
      return;
    end
    chk("valid", 32'(valid4), 32'(q.size() != 0));
    chk("busy", 32'(busy4), 32'(q.size() != 0));
    chk("overrun", 32'(ovr4), 32'(exp_ovr));
    if (q.size() != 0) begin
      chk("data", data4, q[0].data);
      chk("index", {28'd0, row4, col4}, {28'd0, q[0].row, q[0].col});
      chk("last", 32'(last4), 32'(q[0].last));
    end else begin
      chk("last_idle", 32'(last4), 32'd0);
    end
    if (valid4 && rdy4) xfer_cnt++;
    if (ovr4) ovr_cnt++;
    exp_ovr = 1'b0;
    if (q.size() != 0 && rdy4) void'(q.pop_front());
    if (vr4) begin
      if (q.size() == 0) push_matrix();
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pattern(input int kind);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        case (kind)
          0:       c4[r][c] = 32'(16 * r + c);
          1:       c4[r][c] = 32'hFFFF_0000 + 32'(r * 4 + c);
          default: c4[r][c] = $urandom;
        endcase
  endtask

  task automatic start_matrix(input int kind);
    pattern(kind);
    vr4 = 1'b1;
    cycle();
    vr4 = 1'b0;
  endtask

  vec_t tbl[14];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic done;
    n_cmp = 0; n_bad = 0; xfer_cnt = 0; ovr_cnt = 0;
    exp_ovr = 1'b0;
    rst_n = 1'b0;
    vr4 = 1'b0; rdy4 = 1'b1; vr3 = 1'b0; rdy3 = 1'b1;
    pattern(0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        c3[r][c] = 32'(r * 3 + c);

    // N=3 vectors: inputs of a cycle, outputs observed in that same cycle
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 2'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'd0, 2'd0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'd1, 2'd0, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd1, 2'd0, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd2, 2'd0, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'd3, 2'd1, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'd4, 2'd1, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'd5, 2'd1, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'd6, 2'd2, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd7, 2'd2, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'd7, 2'd2, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd8, 2'd2, 2'd2, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'd8, 2'd2, 2'd2, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'd0, 2'd0, 2'd0, 1'b0};

    // Reset values
    cycle();
    cycle();
    chk("n3_rst", {data3[28:0], valid3, last3, busy3}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // N=3 table
    for (int k = 0; k < 14; k++) begin
      vr3  = tbl[k].vr;
      rdy3 = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("n3_valid[%0d]", k), 32'(valid3), 32'(tbl[k].ev));
      chk($sformatf("n3_busy[%0d]", k), 32'(busy3), 32'(tbl[k].ev));
      chk($sformatf("n3_last[%0d]", k), 32'(last3), 32'(tbl[k].el));
      chk($sformatf("n3_ovr[%0d]", k), 32'(ovr3), 32'd0);
      if (tbl[k].ev) begin
        chk($sformatf("n3_data[%0d]", k), data3, tbl[k].ed);
        chk($sformatf("n3_idx[%0d]", k), {28'd0, row3, col3}, {28'd0, tbl[k].er, tbl[k].ec});
      end
      @(posedge clk);
      #1;
    end
    vr3 = 1'b0;

    // Basic stream, ready held high
    xfer_cnt = 0;
    rdy4 = 1'b1;
    start_matrix(0);
    for (int i = 0; i < 20; i++) cycle();
    chk("basic_xfers", 32'(xfer_cnt), 32'd16);

    // Ready pattern 1,0,0,1
    xfer_cnt = 0;
    start_matrix(0);
    for (int i = 0; i < 40; i++) begin
      rdy4 = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    rdy4 = 1'b1;
    chk("stall_xfers", 32'(xfer_cnt), 32'd16);

    // Back-to-back capture on the last transfer
    done = 1'b0;
    ovr_cnt = 0;
    start_matrix(0);
    for (int i = 0; i < 40; i++) begin
      if (!done && q.size() != 0 && q[0].last) begin
        pattern(1);
        vr4 = 1'b1;
        done = 1'b1;
        cycle();
        vr4 = 1'b0;
        chk("b2b_data", data4, 32'hFFFF_0000);
        chk("b2b_valid", 32'(valid4), 32'd1);
      end else begin
        cycle();
      end
    end
    chk("b2b_seen", 32'(done), 32'd1);
    chk("b2b_no_ovr", 32'(ovr_cnt), 32'd0);

    // Overrun during element (1,2)
    done = 1'b0;
    ovr_cnt = 0;
    start_matrix(0);
    for (int i = 0; i < 30; i++) begin
      if (!done && q.size() != 0 && q[0].row == 2'd1 && q[0].col == 2'd2) begin
        pattern(2);
        vr4 = 1'b1;
        done = 1'b1;
        cycle();
        vr4 = 1'b0;
        pattern(0);
        chk("ovr_pulse", 32'(ovr4), 32'd1);
        cycle();
        chk("ovr_one_cycle", 32'(ovr4), 32'd0);
      end else begin
        cycle();
      end
    end
    chk("ovr_seen", 32'(done), 32'd1);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);

    // Reset during element (2,1)
    done = 1'b0;
    start_matrix(0);
    for (int i = 0; i < 20 && !done; i++) begin
      if (q.size() != 0 && q[0].row == 2'd2 && q[0].col == 2'd1) begin
        rst_n = 1'b0;
        done = 1'b1;
        #1;
        chk("arst_outputs", {data4[26:0], row4, col4, valid4}, 32'd0);
        chk("arst_flags", {29'd0, last4, busy4, ovr4}, 32'd0);
      end else begin
        cycle();
      end
    end
    chk("arst_seen", 32'(done), 32'd1);
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    start_matrix(1);
    for (int i = 0; i < 20; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rdy4 = ($urandom_range(0, 3) != 0);
      vr4  = ($urandom_range(0, 19) == 0);
      if (q.size() == 1 && rdy4 && ($urandom_range(0, 1) == 1)) vr4 = 1'b1;
      if (vr4) pattern(2);
      cycle();
    end
    vr4 = 1'b0;
    rdy4 = 1'b1;
    for (int i = 0; i < 20; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
